trig_in_capture: RTL

Receive-side counterpart to the ToF trigger outputs. The block synchronises the `io_trigsIn` pins and detects the first rising edge on each channel after a start event. It timestamps each detected edge against a cycle counter cleared at start and queues `{channel, timestamp}` records in a small FIFO. The Murax peripheral bridge drains the FIFO through a valid/ready read port.

---
 rtl/trig_capture_pkg.sv | 21 ++
 rtl/trig_rec_fifo.sv | 52 +++++
 rtl/trig_in_capture.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/trig_capture_pkg.sv
// Shared state encoding and record-width helpers for the trigger-input capture block.
package trig_capture_pkg;

   typedef logic [1:0] cap_state_t;

   localparam cap_state_t ST_IDLE  = 2'd0;
   localparam cap_state_t ST_ARMED = 2'd1;
   localparam cap_state_t ST_RUN   = 2'd2;
   localparam cap_state_t ST_DRAIN = 2'd3;

   // A single channel still gets one index bit so the record layout never collapses.
   function automatic int ch_bits(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Record layout is {ch, ts}; ch occupies the upper CH_BITS.
   function automatic int rec_width(input int num_ch, input int cnt_width);
      return ch_bits(num_ch) + cnt_width;
   endfunction

endpackage

// File: rtl/trig_rec_fifo.sv
// First-word fall-through record FIFO with registered pointers; a push into a full
// FIFO is accepted when a pop retires the head in the same cycle.
module trig_rec_fifo #(
   parameter int WIDTH = 25,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty   = (wr_q == rd_q);
   assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign head    = empty ? '0 : mem_q[rd_q[AW-1:0]];

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (do_push) wr_d = wr_q + (AW+1)'(1);
      if (do_pop)  rd_d = rd_q + (AW+1)'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/trig_in_capture.sv
// Captures the first rising edge per trigger channel after start, timestamps it
// against a cycle counter and queues {ch, ts} records for the bus bridge.
module trig_in_capture
   import trig_capture_pkg::*;
#(
   parameter int  NUM_CH      = 2,
   parameter int  CNT_WIDTH   = 24,
   parameter int  FIFO_DEPTH  = 8,
   parameter int  SYNC_STAGES = 2,
   localparam int CH_BITS     = ch_bits(NUM_CH),
   localparam int REC_W       = rec_width(NUM_CH, CNT_WIDTH)
) (
   input  logic                 io_mainClk,
   input  logic                 io_asyncReset,
   input  logic [NUM_CH-1:0]    io_trigsIn,
   input  logic                 io_arm,
   input  logic                 io_start,
   input  logic [CNT_WIDTH-1:0] io_timeout,
   output logic                 io_rd_valid,
   input  logic                 io_rd_ready,
   output logic [REC_W-1:0]     io_rd_data,
   output logic                 io_busy,
   output logic                 io_overflow,
   output logic                 io_timedOut
);

   logic [NUM_CH-1:0]    sync_q [SYNC_STAGES];
   logic [NUM_CH-1:0]    sync_d [SYNC_STAGES];
   logic [NUM_CH-1:0]    prev_q, prev_d;
   cap_state_t           state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [NUM_CH-1:0]    captured_q, captured_d;
   logic [NUM_CH-1:0]    pending_q, pending_d;
   logic [CNT_WIDTH-1:0] ts_q [NUM_CH];
   logic [CNT_WIDTH-1:0] ts_d [NUM_CH];
   logic                 overflow_q, overflow_d;
   logic                 timed_out_q, timed_out_d;

   logic [NUM_CH-1:0]    sync_out, rise, grant;
   logic [CH_BITS-1:0]   push_ch;
   logic [CNT_WIDTH-1:0] push_ts;
   logic                 push_req, push, pop, fifo_full, fifo_empty;

   assign sync_out = sync_q[SYNC_STAGES-1];
   // Edge history runs in every state; only detection is qualified by RUN.
   assign rise     = (state_q == ST_RUN) ? (sync_out & ~prev_q & ~captured_q) : '0;

   always_comb begin
      sync_d[0] = io_trigsIn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
      prev_d = sync_out;
   end

   // Lowest pending channel wins; the descending scan leaves the smallest index.
   always_comb begin
      push_req = |pending_q;
      push_ch  = '0;
      push_ts  = '0;
      grant    = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            push_ch  = CH_BITS'(i);
            push_ts  = ts_q[i];
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end

   assign pop  = io_rd_valid & io_rd_ready;
   assign push = push_req & (~fifo_full | pop);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      captured_d  = captured_q;
      pending_d   = pending_q & ~grant;
      ts_d        = ts_q;
      overflow_d  = overflow_q;
      timed_out_d = timed_out_q;
      // A granted record that the FIFO cannot take is dropped but still retired.
      if (push_req && !push) overflow_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (io_arm) begin
               state_d     = ST_ARMED;
               captured_d  = '0;
               pending_d   = '0;
               overflow_d  = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         ST_ARMED: begin
            if (io_start) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            for (int i = 0; i < NUM_CH; i++) begin
               if (rise[i]) begin
                  captured_d[i] = 1'b1;
                  pending_d[i]  = 1'b1;
                  ts_d[i]       = cnt_q;
               end
            end
            if (&captured_d) begin
               state_d = ST_DRAIN;
            end else if (cnt_q == io_timeout) begin
               state_d     = ST_DRAIN;
               timed_out_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (pending_q == '0) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge io_mainClk or posedge io_asyncReset) begin
      if (io_asyncReset) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         for (int i = 0; i < NUM_CH; i++) ts_q[i] <= '0;
         prev_q      <= '0;
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         captured_q  <= '0;
         pending_q   <= '0;
         overflow_q  <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= sync_d[s];
         for (int i = 0; i < NUM_CH; i++) ts_q[i] <= ts_d[i];
         prev_q      <= prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         captured_q  <= captured_d;
         pending_q   <= pending_d;
         overflow_q  <= overflow_d;
         timed_out_q <= timed_out_d;
      end
   end

   trig_rec_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (io_mainClk),
      .rst       (io_asyncReset),
      .push      (push),
      .push_data ({push_ch, push_ts}),
      .pop       (pop),
      .head      (io_rd_data),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign io_rd_valid = ~fifo_empty;
   assign io_busy     = (state_q != ST_IDLE);
   assign io_overflow = overflow_q;
   assign io_timedOut = timed_out_q;

endmodule
